// File: rtl/pipe_mdu_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit: op codes, FSM states
// and the default datapath width.
package pipe_mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110,
    MDU_NOP7  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // True for the ops that take the multi-cycle iterative path.
  function automatic logic op_is_iter(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/pipe_mdu_if.sv
// EXE-stage <-> MDU bundle: op request, read select and the HI/LO/busy view.
interface pipe_mdu_if #(parameter int WIDTH = pipe_mdu_pkg::MDU_WIDTH);
  import pipe_mdu_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_lo_sel;
  logic             busy;
  logic [WIDTH-1:0] mdu_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  mdu_state_e       dbg_state;

  // Handshake: an op is taken on a rising edge where start && !busy; a start
  // seen while busy is dropped (no queueing), so the master must hold off.
  modport master (
    output start, op, a, b, hi_lo_sel,
    input  busy, mdu_out, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, hi_lo_sel,
    output busy, mdu_out, hi, lo, dbg_state
  );

endinterface

// File: rtl/pipe_mdu_iter_core.sv
// Unsigned iterative datapath: one radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on a 2*WIDTH accumulator.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_opa,
  input  logic [WIDTH-1:0]   i_opb,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, (i_is_div ? i_opa : i_opb)};
      r_m   <= i_is_div ? i_opb : i_opa;
      r_div <= i_is_div;
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pipe_mdu.sv
// EXE-stage multiply/divide unit owning HI/LO: iterative MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, combinational MFHI/MFLO read port.
module pipe_mdu
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  pipe_mdu_if.slave mdu
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       r_state;
  mdu_state_e       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_div;
  logic             r_div0;
  logic [WIDTH-1:0] r_raw_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic               w_accept;
  logic               w_is_signed;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_mthi;
  logic               w_mtlo;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Operand conditioning: signed ops iterate on magnitudes, signs fixed in FIX.
  always_comb begin
    w_accept    = mdu.start && !r_busy;
    w_is_signed = (mdu.op == MDU_MULT) || (mdu.op == MDU_DIV);
    w_is_div    = (mdu.op == MDU_DIV)  || (mdu.op == MDU_DIVU);
    w_sa        = w_is_signed && mdu.a[WIDTH-1];
    w_sb        = w_is_signed && mdu.b[WIDTH-1];
    w_mag_a     = w_sa ? -mdu.a : mdu.a;
    w_mag_b     = w_sb ? -mdu.b : mdu.b;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MDU_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (w_accept) begin
          if (op_is_iter(mdu.op)) begin
            w_load       = 1'b1;
            w_next_state = MDU_RUN;
          end
          w_mthi = (mdu.op == MDU_MTHI);
          w_mtlo = (mdu.op == MDU_MTLO);
        end
      end
      MDU_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) w_next_state = MDU_FIX;
      end
      MDU_FIX: begin
        w_fix        = 1'b1;
        w_next_state = MDU_IDLE;
      end
      default: w_next_state = MDU_IDLE;
    endcase
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_opa    (w_mag_a),
    .i_opb    (w_mag_b),
    .o_acc    (w_acc)
  );

  // Divide-by-zero bypasses sign correction: LO all-ones, HI the raw dividend.
  always_comb begin
    w_prod = r_neg_q ? -w_acc : w_acc;
    w_quot = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    if (!r_is_div) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_div0) begin
      w_res_hi = r_raw_a;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_raw_a  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_load) begin
        r_busy   <= 1'b1;
        r_cnt    <= '0;
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_is_div <= w_is_div;
        r_div0   <= (mdu.b == '0);
        r_raw_a  <= mdu.a;
      end
      if (w_step) r_cnt <= r_cnt + CW'(1);
      if (w_fix) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_busy <= 1'b0;
      end
      if (w_mthi) r_hi <= mdu.a;
      if (w_mtlo) r_lo <= mdu.a;
    end
  end

  assign mdu.busy      = r_busy;
  assign mdu.hi        = r_hi;
  assign mdu.lo        = r_lo;
  assign mdu.mdu_out   = mdu.hi_lo_sel ? r_hi : r_lo;
  assign mdu.dbg_state = r_state;

endmodule
